// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and default widths for the I2C master arbiter.
package i2c_master_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_REGISTER_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH  = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_COMPLETE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit after last_owner, wrapping.
module i2c_arbiter_rr_picker #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]    last_owner,
  output logic                      valid,
  output logic [INDEX_WIDTH-1:0]    index
);

  logic [INDEX_WIDTH-1:0] cand;

  // Scan last_owner+1 .. last_owner+N so the previous owner ranks lowest.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = INDEX_WIDTH'((32'(last_owner) + k) % NUM_REQUESTERS);
      if (!valid && request[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQUESTERS clients.
// Optional watchdog enabled by defining I2C_ARBITER_TIMEOUT_EN.
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            request,
  input  logic [NUM_REQUESTERS-1:0]            read_write,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] mosi_data,
  input  logic [NUM_REQUESTERS*REGISTER_WIDTH-1:0] register_address,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0]  device_address,
  output logic [NUM_REQUESTERS-1:0]            grant,
  output logic [NUM_REQUESTERS-1:0]            done,
  output logic [NUM_REQUESTERS-1:0]            error,
  output logic [DATA_WIDTH-1:0]                miso_data,
  output logic                                 master_enable,
  output logic                                 master_read_write,
  output logic [DATA_WIDTH-1:0]                master_mosi_data,
  output logic [REGISTER_WIDTH-1:0]            master_register_address,
  output logic [ADDRESS_WIDTH-1:0]             master_device_address,
  input  logic [DATA_WIDTH-1:0]                master_miso_data,
  input  logic                                 master_busy
);

  localparam int unsigned IW = $clog2(NUM_REQUESTERS);

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("i2c_master_arbiter: unsupported NUM_REQUESTERS or TIMEOUT_CYCLES");
  end

  arb_state_t                state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic [IW-1:0]             last_owner_q, last_owner_d;
  logic [IW-1:0]             pick_index;
  logic                      pick_valid;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] done_q, done_d;
  logic [NUM_REQUESTERS-1:0] owner_onehot;
  logic [DATA_WIDTH-1:0]     miso_q, miso_d;
  logic                      men_q, men_d;
  logic                      mrw_q, mrw_d;
  logic [DATA_WIDTH-1:0]     mdata_q, mdata_d;
  logic [REGISTER_WIDTH-1:0] mreg_q, mreg_d;
  logic [ADDRESS_WIDTH-1:0]  mdev_q, mdev_d;
  logic                      finish;
  logic                      expired;

  i2c_arbiter_rr_picker #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .INDEX_WIDTH    (IW)
  ) u_picker (
    .request    (request),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  assign owner_onehot = NUM_REQUESTERS'(1) << owner_q;

`ifdef I2C_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NUM_REQUESTERS-1:0] error_q, error_d;

  // Last counted cycle of the budget: completion lands on the next edge.
  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign error   = error_q;
`else
  assign expired = 1'b0;
  assign error   = '0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    done_d       = '0;
    miso_d       = miso_q;
    men_d        = men_q;
    mrw_d        = mrw_q;
    mdata_d      = mdata_q;
    mreg_d       = mreg_q;
    mdev_d       = mdev_q;
    finish       = 1'b0;
`ifdef I2C_ARBITER_TIMEOUT_EN
    error_d      = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          owner_d = pick_index;
          grant_d = NUM_REQUESTERS'(1) << pick_index;
          men_d   = 1'b1;
          mrw_d   = read_write[pick_index];
          mdata_d = mosi_data[32'(pick_index)*DATA_WIDTH +: DATA_WIDTH];
          mreg_d  = register_address[32'(pick_index)*REGISTER_WIDTH +: REGISTER_WIDTH];
          mdev_d  = device_address[32'(pick_index)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
      end
      ST_ISSUE: begin
        if (expired) begin
          finish = 1'b1;
        end else if (master_busy) begin
          men_d   = 1'b0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (expired || !master_busy) finish = 1'b1;
      end
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Shared completion path: normal end of busy or watchdog expiry.
    if (finish) begin
      state_d      = ST_COMPLETE;
      miso_d       = expired ? '0 : master_miso_data;
      done_d       = owner_onehot;
      grant_d      = '0;
      men_d        = 1'b0;
      last_owner_d = owner_q;
`ifdef I2C_ARBITER_TIMEOUT_EN
      error_d      = expired ? owner_onehot : '0;
`endif
    end

`ifdef I2C_ARBITER_TIMEOUT_EN
    cnt_d = (state_d == state_q && (state_q == ST_ISSUE || state_q == ST_WAIT_BUSY))
            ? cnt_q + CW'(1) : '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQUESTERS - 1);
      grant_q      <= '0;
      done_q       <= '0;
      miso_q       <= '0;
      men_q        <= 1'b0;
      mrw_q        <= 1'b0;
      mdata_q      <= '0;
      mreg_q       <= '0;
      mdev_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      miso_q       <= miso_d;
      men_q        <= men_d;
      mrw_q        <= mrw_d;
      mdata_q      <= mdata_d;
      mreg_q       <= mreg_d;
      mdev_q       <= mdev_d;
    end
  end

`ifdef I2C_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      error_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
`endif

  assign grant                   = grant_q;
  assign done                    = done_q;
  assign miso_data               = miso_q;
  assign master_enable           = men_q;
  assign master_read_write       = mrw_q;
  assign master_mosi_data        = mdata_q;
  assign master_register_address = mreg_q;
  assign master_device_address   = mdev_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a behavioural i2c_master/slave stand-in.
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 8;
  localparam int AW = 7;
`ifdef I2C_ARBITER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    request = '0;
  logic [N-1:0]    read_write = '0;
  logic [N*DW-1:0] mosi_data = '0;
  logic [N*RW-1:0] register_address = '0;
  logic [N*AW-1:0] device_address = {N{7'h11}};
  logic [N-1:0]    grant, done, error;
  logic [DW-1:0]   miso_data;
  logic            master_enable, master_read_write;
  logic [DW-1:0]   master_mosi_data;
  logic [RW-1:0]   master_register_address;
  logic [AW-1:0]   master_device_address;
  logic [DW-1:0]   master_miso_data = '0;
  logic            master_busy = 1'b0;

  i2c_master_arbiter #(
    .NUM_REQUESTERS (N),
    .DATA_WIDTH     (DW),
    .REGISTER_WIDTH (RW),
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .request                 (request),
    .read_write              (read_write),
    .mosi_data               (mosi_data),
    .register_address        (register_address),
    .device_address          (device_address),
    .grant                   (grant),
    .done                    (done),
    .error                   (error),
    .miso_data               (miso_data),
    .master_enable           (master_enable),
    .master_read_write       (master_read_write),
    .master_mosi_data        (master_mosi_data),
    .master_register_address (master_register_address),
    .master_device_address   (master_device_address),
    .master_miso_data        (master_miso_data),
    .master_busy             (master_busy)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          failed = 0;
  bit          force_low = 1'b0;
  int          phase = 0;
  logic        m_rw = 1'b0;
  logic [7:0]  m_reg = '0;
  logic [7:0]  m_data = '0;
  logic [6:0]  m_dev = '0;
  logic [7:0]  slave_regs [256];
  int          done_total = 0;
  int          enable_strobes = 0;
  int          unstable = 0;
  logic        prev_en = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic [23:0] snap = '0;

  // Master/slave stand-in: busy rises 2 cycles after the strobe, lasts 6 cycles.
  always @(negedge clock) begin
    if (reset || force_low) begin
      master_busy = 1'b0;
      phase = 0;
    end else if (phase == 0) begin
      if (master_enable) begin
        phase  = 1;
        m_rw   = master_read_write;
        m_reg  = master_register_address;
        m_data = master_mosi_data;
        m_dev  = master_device_address;
      end
    end else begin
      phase++;
      if (phase == 3) master_busy = 1'b1;
      else if (phase == 9) begin
        master_busy = 1'b0;
        phase = 0;
        if (m_dev == 7'h11) begin
          if (m_rw) master_miso_data = slave_regs[m_reg];
          else slave_regs[m_reg] = m_data;
        end
      end
    end
    if (master_enable && !prev_en) enable_strobes++;
    prev_en = master_enable;
    if (done != '0) done_total++;
    if (grant != '0) begin
      if (grant != prev_grant)
        snap = {master_read_write, master_mosi_data, master_register_address, master_device_address};
      else if (snap != {master_read_write, master_mosi_data, master_register_address, master_device_address})
        unstable++;
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [7:0] ra, input logic [7:0] wd);
    read_write[i] = rw;
    register_address[i*RW +: RW] = ra;
    mosi_data[i*DW +: DW] = wd;
  endtask

  // Advance until a done pulse; counts cycles where grant differs from hold.
  task automatic wait_done(input int budget, input logic [N-1:0] hold, output int bad);
    int cycles = 0;
    bad = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (done != '0) break;
      if (hold != '0 && grant != hold) bad++;
    end
    check("done_seen", 32'(done != '0), 1);
    check("error_quiet", 32'(error), 0);
  endtask

  task automatic wait_busy_phase(input int budget);
    int w = 0;
    while (!(master_busy && !master_enable) && w < budget) begin
      tick();
      w++;
    end
    check("reach_wait_busy", 32'(master_busy && !master_enable), 1);
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, gap, base;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (3) tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_enable", 32'(master_enable), 0);
    check("rst_rw", 32'(master_read_write), 0);
    check("rst_mosi", 32'(master_mosi_data), 0);
    check("rst_reg", 32'(master_register_address), 0);
    check("rst_dev", 32'(master_device_address), 0);
    check("rst_miso", 32'(miso_data), 0);
    reset = 1'b0;

    // req0 write reg 02 = A5, request dropped mid-transaction
    set_cmd(0, 1'b0, 8'h02, 8'hA5);
    request = 4'b0001;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_enable", 32'(master_enable), 1);
    check("t1_mosi", 32'(master_mosi_data), 32'hA5);
    check("t1_reg", 32'(master_register_address), 32'h02);
    check("t1_dev", 32'(master_device_address), 32'h11);
    request = 4'b0000;
    wait_done(200, 4'b0001, bad);
    check("t1_done", 32'(done), 32'h1);
    check("t1_strobes", 32'(enable_strobes), 1);
    check("t1_slave_reg", 32'(slave_regs[2]), 32'hA5);

    // req1 read reg 02, grant held until completion
    tick();
    set_cmd(1, 1'b1, 8'h02, 8'h00);
    request = 4'b0010;
    tick();
    check("t2_grant", 32'(grant), 32'h2);
    check("t2_rw", 32'(master_read_write), 1);
    wait_done(200, 4'b0010, bad);
    check("t2_done", 32'(done), 32'h2);
    check("t2_miso", 32'(miso_data), 32'hA5);
    check("t2_grant_held", 32'(bad), 0);
    check("t2_grant_clear", 32'(grant), 0);
    request = 4'b0000;

    // All four held from reset: 0,1,2,3,0 with a 2-cycle done-to-enable gap
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_cmd(0, 1'b0, 8'h10, 8'h11);
    set_cmd(1, 1'b0, 8'h11, 8'h22);
    set_cmd(2, 1'b0, 8'h12, 8'h33);
    set_cmd(3, 1'b1, 8'h02, 8'h00);
    base = done_total;
    request = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_done(200, 4'b0000, bad);
      order[g] = idx_of(done);
      check("t3_onehot", 32'($countones(done)), 1);
      check("t3_order", 32'(order[g]), 32'(exp_order[g]));
      if (g == 3) check("t3_read_miso", 32'(miso_data), 32'hA5);
      if (g == 4) request = 4'b0000;
      else begin
        gap = 0;
        do begin
          tick();
          gap++;
        end while (!master_enable && gap < 10);
        check("t3_gap", 32'(gap), 2);
      end
    end
    tick();
    check("t3_done_total", 32'(done_total - base), 5);
    check("t3_slave_reg12", 32'(slave_regs[8'h12]), 32'h33);

    // req2 alone; req0 joins during WAIT_BUSY and is served next
    set_cmd(2, 1'b0, 8'h05, 8'h3C);
    set_cmd(0, 1'b0, 8'h06, 8'h77);
    request = 4'b0100;
    tick();
    check("t4_grant", 32'(grant), 32'h4);
    mosi_data[2*DW +: DW] = 8'hFF;
    wait_busy_phase(50);
    request = 4'b0101;
    wait_done(200, 4'b0100, bad);
    check("t4_done2", 32'(done), 32'h4);
    check("t4_mosi_held", 32'(master_mosi_data), 32'h3C);
    check("t4_grant_held", 32'(bad), 0);
    check("t4_slave_reg05", 32'(slave_regs[8'h05]), 32'h3C);
    wait_done(200, 4'b0000, bad);
    check("t4_done0", 32'(done), 32'h1);
    request = 4'b0000;
    check("t4_cmd_stable", 32'(unstable), 0);

    // Reset during WAIT_BUSY abandons req1; req0 wins after reset
    tick();
    set_cmd(1, 1'b0, 8'h07, 8'h5A);
    set_cmd(0, 1'b0, 8'h08, 8'h66);
    request = 4'b0010;
    tick();
    tick();
    check("t5_grant1", 32'(grant), 32'h2);
    wait_busy_phase(50);
    base = done_total;
    reset = 1'b1;
    request = 4'b0011;
    tick();
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_enable", 32'(master_enable), 0);
    check("t5_rst_mosi", 32'(master_mosi_data), 0);
    check("t5_rst_reg", 32'(master_register_address), 0);
    check("t5_rst_dev", 32'(master_device_address), 0);
    check("t5_rst_miso", 32'(miso_data), 0);
    reset = 1'b0;
    tick();
    check("t5_no_done", 32'(done_total - base), 0);
    check("t5_grant0", 32'(grant), 32'h1);
    request = 4'b0000;
    wait_done(200, 4'b0001, bad);
    check("t5_done0", 32'(done), 32'h1);
    check("t5_slave_reg08", 32'(slave_regs[8'h08]), 32'h66);
    check("t5_slave_reg07", 32'(slave_regs[8'h07] === 8'h5A), 0);

`ifdef I2C_ARBITER_TIMEOUT_EN
    // Watchdog: busy never rises, done+error on cycle 101 after ISSUE entry
    tick();
    force_low = 1'b1;
    set_cmd(0, 1'b1, 8'h02, 8'h00);
    request = 4'b0001;
    tick();
    check("t6_enable", 32'(master_enable), 1);
    request = 4'b0000;
    gap = 1;
    while (done == '0 && gap < 300) begin
      tick();
      gap++;
    end
    check("t6_cycle", 32'(gap), 101);
    check("t6_done", 32'(done), 32'h1);
    check("t6_error", 32'(error), 32'h1);
    check("t6_miso", 32'(miso_data), 0);
    check("t6_enable_clr", 32'(master_enable), 0);
    force_low = 1'b0;
    tick();
    check("t6_error_pulse", 32'(error), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQUESTERS, default 4, giving the number of requester ports (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the data fields.
REQ-003 The block SHALL have parameter REGISTER_WIDTH, default 8, giving the width of the register address.
REQ-004 The block SHALL have parameter ADDRESS_WIDTH, default 7, giving the width of the device address.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the watchdog limit in clocks.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset:
  clock  in  1  single clock; all logic is on the rising edge
  reset  in  1  synchronous, active-high reset
REQ-007 The requester-side ports SHALL be:
  request           in   NUM_REQUESTERS                  per-requester transaction request, level
  read_write        in   NUM_REQUESTERS                  per-requester direction, 1 = read
  mosi_data         in   NUM_REQUESTERS*DATA_WIDTH       packed write data, requester i in slice i
  register_address  in   NUM_REQUESTERS*REGISTER_WIDTH   packed register addresses
  device_address    in   NUM_REQUESTERS*ADDRESS_WIDTH    packed device addresses
  grant             out  NUM_REQUESTERS                  one-hot owner of the current transaction
  done              out  NUM_REQUESTERS                  one-cycle completion pulse
  error             out  NUM_REQUESTERS                  one-cycle timeout pulse, coincident with done
  miso_data         out  DATA_WIDTH                      read data of the last completed transaction
REQ-008 The master-side ports SHALL be:
  master_enable            out  1               start strobe to i2c_master
  master_read_write        out  1               registered direction
  master_mosi_data         out  DATA_WIDTH      registered write data
  master_register_address  out  REGISTER_WIDTH  registered register address
  master_device_address    out  ADDRESS_WIDTH   registered device address
  master_miso_data         in   DATA_WIDTH      read data from i2c_master
  master_busy              in   1               busy flag from i2c_master

Function
REQ-009 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and COMPLETE.
REQ-010 In IDLE with any request bit set, the block SHALL select a winner round-robin, starting at last_owner+1 and wrapping modulo NUM_REQUESTERS.
REQ-011 On the same edge, the block SHALL register the winner's command fields onto the master_* outputs, set grant to the winner's one-hot code, and enter ISSUE.
REQ-012 In ISSUE, master_enable SHALL be 1; on the first cycle with master_busy=1, the block SHALL clear master_enable and enter WAIT_BUSY.
REQ-013 In WAIT_BUSY, the block SHALL enter COMPLETE on the first cycle with master_busy=0.
REQ-014 In COMPLETE (one cycle), the block SHALL:
  - latch miso_data from master_miso_data;
  - pulse done[owner];
  - clear grant;
  - set last_owner to owner;
  - return to IDLE.
REQ-015 The master_* command outputs SHALL remain stable from IDLE exit until COMPLETE.
REQ-016 A requester dropping request mid-transaction SHALL NOT abort it; the transaction completes and done is still pulsed.
REQ-017 A requester still holding request at its own done SHALL rank lowest among the requesters in the next arbitration.
REQ-018 With a single active requester, the minimum gap from done to the next master_enable SHALL be 2 clocks (one IDLE cycle, then ISSUE).
REQ-019 Request changes during ISSUE, WAIT_BUSY or COMPLETE SHALL be ignored until the FSM is back in IDLE.

Reset
REQ-020 While reset=1 at a rising edge, the block SHALL:
  - go to state IDLE;
  - drive grant, done, error, master_enable, master_read_write = 0;
  - drive miso_data and the master_* data/address outputs = 0;
  - set last_owner = NUM_REQUESTERS-1, so requester 0 wins first;
  - clear the watchdog counter.
REQ-021 A reset asserted mid-transaction SHALL abandon the transaction without pulsing done or error.

Configuration
REQ-022 With I2C_ARBITER_TIMEOUT_EN defined, a counter SHALL run in ISSUE and WAIT_BUSY and clear on each state entry.
REQ-023 If that counter reaches TIMEOUT_CYCLES, the block SHALL enter COMPLETE with miso_data=0, pulse done[owner] and error[owner], and clear master_enable.
REQ-024 Without I2C_ARBITER_TIMEOUT_EN, the block SHALL have no counter, error SHALL be tied to 0, and ISSUE/WAIT_BUSY SHALL wait indefinitely.

Structure
REQ-025 Package i2c_master_arbiter_pkg SHALL hold the state enum and the default width constants (8/8/7).
REQ-026 The combinational round-robin selection SHALL be a single sub-module, i2c_arbiter_rr_picker, with inputs request and last_owner and outputs valid and index.

Verification
REQ-027 The bench SHALL use i2c_master with divider=16'h0003, the i2c_slave model at device 7'h11, and pullups, and SHALL cover:
  - req0 write reg 8'h02 data 8'hA5 -> one master_enable strobe, done[0] pulse, slave reg 8'h02 reads back 8'hA5.
  - req1 read reg 8'h02 -> miso_data=8'hA5 on done[1], grant[1] high from arbitration to COMPLETE.
  - request=4'b1111 held at start -> grants in order 0,1,2,3,0, each done exactly once per grant.
  - req2 asserted alone, req0 asserted during req2's WAIT_BUSY -> req0 is served next, and req2's command outputs stay unchanged throughout.
  - reset pulsed during WAIT_BUSY -> all outputs 0 next cycle, no done, req0 wins the next arbitration.
  - with I2C_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=100 and master_busy forced 0 -> done[0] and error[0] on cycle 101 after ISSUE entry, miso_data=0.
